// File: rtl/ad5453_wave_player.sv
// Sample buffer and playback sequencer for one AD5453 DAC channel, 16-bit SPI frames.
// Optional: define AD5453_PARK_ON_STOP_EN to send a final midscale frame before done.
module ad5453_wave_player #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [13:0]           wr_data,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [PERIOD_W-1:0]   period,
    output logic                  sdi,
    output logic                  csb,
    output logic                  sclk,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned HW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0]         H_LAST = HW'(CLK_DIV - 1);
    localparam logic [DEPTH_LOG2:0]   FULL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [5:0]            HP_GAP = 6'd33;

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
    state_t state, state_next;

    logic [13:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0]  rd_ptr, rd_next;
    logic [PERIOD_W-1:0]  period_q, tcnt;
    logic                 ser_busy, ser_last, ser_free;
    logic [5:0]           hp;
    logic [HW-1:0]        hcnt;
    logic [15:0]          shreg;
    logic                 tick, launch, adv_ptr, wrap_ptr, set_ovr, start_play, finish;
    logic [13:0]          launch_code;
`ifdef AD5453_PARK_ON_STOP_EN
    logic                 parked;
`endif

    // The final cycle of the SYNC gap counts as free so period = 34*H-1 runs back-to-back.
    assign ser_last = ser_busy && (hp == HP_GAP) && (hcnt == H_LAST);
    assign ser_free = !ser_busy || ser_last;
    assign tick     = (tcnt == '0);
    assign rd_next  = rd_ptr + ONE;

    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        launch_code = mem[rd_ptr[DEPTH_LOG2-1:0]];
        adv_ptr     = 1'b0;
        wrap_ptr    = 1'b0;
        set_ovr     = 1'b0;
        start_play  = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !clear && count != '0) begin
                    state_next = PLAY;
                    start_play = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_next = DRAIN;
                end else if (tick) begin
                    if (!ser_free) begin
                        set_ovr = 1'b1;
                    end else begin
                        launch = 1'b1;
                        if (rd_next == count && loop_en) wrap_ptr = 1'b1;
                        else adv_ptr = 1'b1;
                        if (rd_next == count && !loop_en) state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ser_free) begin
`ifdef AD5453_PARK_ON_STOP_EN
                    if (!parked) begin
                        launch      = 1'b1;
                        launch_code = 14'h2000;
                    end else begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end
`else
                    state_next = IDLE;
                    finish     = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && !clear && wr_en && count != FULL)
            mem[count[DEPTH_LOG2-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            period_q <= '0;
            tcnt     <= '0;
            overrun  <= 1'b0;
            done     <= 1'b0;
            ser_busy <= 1'b0;
            hp       <= '0;
            hcnt     <= '0;
            shreg    <= '0;
`ifdef AD5453_PARK_ON_STOP_EN
            parked   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            done  <= finish;

            if (state == IDLE) begin
                if (clear) count <= '0;
                else if (wr_en && count != FULL) count <= count + ONE;
            end

            if (start_play) begin
                period_q <= period;
                overrun  <= 1'b0;
                rd_ptr   <= '0;
                tcnt     <= '0;
`ifdef AD5453_PARK_ON_STOP_EN
                parked   <= 1'b0;
`endif
            end else begin
                if (state == PLAY) tcnt <= tick ? period_q : tcnt - PERIOD_W'(1);
                if (set_ovr) overrun <= 1'b1;
                if (wrap_ptr) rd_ptr <= '0;
                else if (adv_ptr) rd_ptr <= rd_next;
            end

            if (launch) begin
                ser_busy <= 1'b1;
                hp       <= '0;
                hcnt     <= '0;
                shreg    <= {2'b00, launch_code};
`ifdef AD5453_PARK_ON_STOP_EN
                if (state == DRAIN) parked <= 1'b1;
`endif
            end else if (ser_busy) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    if (hp == HP_GAP) begin
                        ser_busy <= 1'b0;
                    end else begin
                        hp <= hp + 6'd1;
                        // sdi advances on rising edges 1..15 only; bit 0 holds through the 16th
                        if (hp[0] && hp < 6'd30) shreg <= {shreg[14:0], 1'b0};
                    end
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign csb  = !(ser_busy && hp != HP_GAP);
    assign sclk = !(ser_busy && hp[0]);
    assign sdi  = ser_busy && (hp != HP_GAP) && shreg[15];

endmodule

// File: tb/tb_ad5453_wave_player.sv
// Scoreboard bench for ad5453_wave_player; decodes SPI frames and checks code, timing and spacing.
// Honours AD5453_PARK_ON_STOP_EN by expecting the trailing midscale frame.
module tb_ad5453_wave_player;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst, wr_en, clear, start, stop, loop_en;
    logic [13:0] wr_data;
    logic [15:0] period;
    logic        sdi, csb, sclk, busy, done, overrun;
    logic [6:0]  count;

    ad5453_wave_player #(.DEPTH_LOG2(6), .CLK_DIV(H), .PERIOD_W(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
        .start(start), .stop(stop), .loop_en(loop_en), .period(period),
        .sdi(sdi), .csb(csb), .sclk(sclk), .busy(busy), .done(done),
        .overrun(overrun), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] code;
        int          gap;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launches = 0;
    int done_cnt = 0;
    bit ignore = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] code, input int gap);
        exp_t e;
        e.code = code;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_park();
`ifdef AD5453_PARK_ON_STOP_EN
        push(16'h2000, 34 * H);
`endif
    endtask

    // Monitor: sampled on the falling clk edge, away from DUT updates.
    always @(posedge clk) cyc++;

    int   last_launch = 0, cur_gap = 0, low_len = 0, bits = 0, pulses = 0, low_w = 0, width_bad = 0;
    logic [15:0] word = '0;
    logic prev_csb = 1'b1, prev_sclk = 1'b1, prev_done = 1'b0;

    always @(negedge clk) begin
        if (!csb) begin
            if (prev_csb) begin
                launches++;
                cur_gap     = cyc - last_launch;
                last_launch = cyc;
                low_len = 0; bits = 0; pulses = 0; low_w = 0; width_bad = 0; word = '0;
            end
            low_len++;
            if (!sclk) begin
                if (prev_sclk) begin
                    word = {word[14:0], sdi};
                    bits++;
                    pulses++;
                    low_w = 0;
                end
                low_w++;
            end else if (!prev_sclk && !prev_csb) begin
                if (low_w != H) width_bad++;
            end
        end else if (!prev_csb && !ignore) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {16'h0, word}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_code", {16'h0, word}, {16'h0, e.code});
                chk("frame_bits", bits, 16);
                chk("csb_low_cycles", low_len, 33 * H);
                chk("sclk_low_pulses", pulses, 16);
                chk("sclk_low_width_bad", width_bad, 0);
                chk("gap_sdi", {31'h0, sdi}, 0);
                if (e.gap != 0) chk("frame_spacing", cur_gap, e.gap);
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_busy", {31'h0, busy}, 0);
            chk("done_single", {31'h0, prev_done}, 0);
        end
        prev_csb  = csb;
        prev_sclk = sclk;
        prev_done = done;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] code);
        wr_data = code; wr_en = 1'b1; step(); wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        step();
    endtask

    task automatic wait_launches(input int target, input int limit);
        int i = 0;
        while (launches < target && i < limit) begin
            step();
            i++;
        end
        if (launches < target) begin
            checks++; errors++;
            $display("FAIL launch_timeout actual=%0d required=%0d", launches, target);
        end
    endtask

    function automatic logic [13:0] code_of(input int i);
        return 14'(i * 257 + 3);
    endfunction

    int d0, l0;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0;
        stop = 1'b0; loop_en = 1'b0; period = '0;
        step(3);
        chk("rst_sdi", {31'h0, sdi}, 0);
        chk("rst_csb", {31'h0, csb}, 1);
        chk("rst_sclk", {31'h0, sclk}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_overrun", {31'h0, overrun}, 0);
        chk("rst_count", {25'h0, count}, 0);
        rst = 1'b0;
        step();

        // Three codes, period 99, one-shot.
        wr(14'h0001); wr(14'h1ABC); wr(14'h3FFF);
        chk("load3_count", {25'h0, count}, 3);
        period = 16'd99; loop_en = 1'b0;
        push(16'h0001, 0); push(16'h1ABC, 100); push(16'h3FFF, 100); push_park();
        d0 = done_cnt;
        pulse_start();
        chk("busy_after_start", {31'h0, busy}, 1);
        wait_done(1000, "run1");
        chk("run1_done_pulses", done_cnt - d0, 1);
        chk("run1_count", {25'h0, count}, 3);
        chk("run1_busy", {31'h0, busy}, 0);
        chk("run1_overrun", {31'h0, overrun}, 0);
        chk("run1_queue", exp_q.size(), 0);

        // Loop two codes, stop after five frames.
        pulse_clear();
        wr(14'h0AAA); wr(14'h1555);
        period = 16'd199; loop_en = 1'b1;
        push(16'h0AAA, 0); push(16'h1555, 200); push(16'h0AAA, 200);
        push(16'h1555, 200); push(16'h0AAA, 200); push_park();
        l0 = launches; d0 = done_cnt;
        pulse_start();
        wait_launches(l0 + 5, 1500);
        stop = 1'b1; step(); stop = 1'b0;
        wait_done(500, "loop");
        step(300);
        chk("loop_done_pulses", done_cnt - d0, 1);
        chk("loop_busy", {31'h0, busy}, 0);
`ifdef AD5453_PARK_ON_STOP_EN
        chk("loop_launches", launches - l0, 6);
`else
        chk("loop_launches", launches - l0, 5);
`endif
        chk("loop_queue", exp_q.size(), 0);
        loop_en = 1'b0;

        // Fill to depth, drop the 65th, ignore writes during playback; period 67 is the overrun-free edge.
        pulse_clear();
        chk("clear_count", {25'h0, count}, 0);
        for (int i = 0; i < 64; i++) wr(code_of(i));
        wr(14'h3333);
        chk("full_count", {25'h0, count}, 64);
        period = 16'd67;
        for (int i = 0; i < 64; i++) push({2'b00, code_of(i)}, (i == 0) ? 0 : 34 * H);
        push_park();
        pulse_start();
        step(10);
        wr(14'h1111);
        chk("play_write_count", {25'h0, count}, 64);
        wait_done(64 * 68 + 400, "full");
        chk("full_overrun", {31'h0, overrun}, 0);
        chk("full_queue", exp_q.size(), 0);

        // Empty buffer start is ignored.
        pulse_clear();
        d0 = done_cnt;
        pulse_start();
        step(5);
        chk("empty_busy", {31'h0, busy}, 0);
        chk("empty_done", done_cnt - d0, 0);

        // Period 10 forces overruns; next start clears overrun.
        wr(14'h0123); wr(14'h2345);
        period = 16'd10;
        push(16'h0123, 0); push(16'h2345, 77); push_park();
        pulse_start();
        wait_done(1000, "ovr");
        chk("ovr_set", {31'h0, overrun}, 1);
        chk("ovr_queue", exp_q.size(), 0);
        period = 16'd99;
        push(16'h0123, 0); push(16'h2345, 100); push_park();
        pulse_start();
        chk("ovr_cleared", {31'h0, overrun}, 0);
        wait_done(1000, "ovr2");
        chk("ovr2_overrun", {31'h0, overrun}, 0);
        chk("ovr2_queue", exp_q.size(), 0);

        // Reset in the middle of a frame.
        ignore = 1'b1;
        l0 = launches;
        pulse_start();
        wait_launches(l0 + 1, 200);
        step(20);
        chk("mid_csb_low", {31'h0, csb}, 0);
        rst = 1'b1; step();
        chk("midrst_csb", {31'h0, csb}, 1);
        chk("midrst_sclk", {31'h0, sclk}, 1);
        chk("midrst_sdi", {31'h0, sdi}, 0);
        chk("midrst_busy", {31'h0, busy}, 0);
        chk("midrst_count", {25'h0, count}, 0);
        rst = 1'b0;
        step(3);
        ignore = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
